fwd_hazard_unit: RTL and testbench

Generates the select codes driving the EX-stage 3:1 operand forwarding muxes (2'b00 register file, 2'b01 EX/MEM result, 2'b10 MEM/WB result). It also generates the pipeline stall and bubble controls. It sits beside the ID/EX boundary and keeps its own shadow copy of the destination-register state of the instructions in EX and MEM. The shadow copy advances in lockstep with the pipeline registers.

---
 rtl/fwd_hazard_unit_pkg.sv | 31 +++
 rtl/fwd_hazard_unit_dep.sv | 17 +
 rtl/fwd_hazard_unit.sv | 111 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared select codes, shadow-stage record and forward-priority helper for fwd_hazard_unit.
package fwd_hazard_unit_pkg;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   // Shadow rd is stored at a fixed width; register addresses up to this wide are supported.
   localparam int SHADOW_AW = 8;

   typedef logic [SHADOW_AW-1:0] shadow_rd_t;

   typedef struct packed {
      logic       v;
      logic       ld;
      shadow_rd_t rd;
   } shadow_t;

   localparam shadow_t SHADOW_EMPTY = '{v: 1'b0, ld: 1'b0, rd: '0};

   // The youngest producer (EX) wins over MEM.
   function automatic logic [1:0] fwd_sel(input logic match_ex, input logic match_mem);
      if (match_ex)
         return FWD_EXMEM;
      else if (match_mem)
         return FWD_MEMWB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_dep.sv
// dep_cmp: single-operand dependence comparator against one shadow pipeline stage.
module dep_cmp
   import fwd_hazard_unit_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              src_use,
   input  logic [REG_AW-1:0] addr,
   input  logic              stage_v,
   input  shadow_rd_t        stage_rd,
   output logic              match
);

   // r0 is hard-wired zero, so a write to it never creates a dependence.
   assign match = src_use && stage_v && (shadow_rd_t'(addr) == stage_rd) && (addr != '0);

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding selects plus stall/bubble control, tracking EX/MEM destinations in a shadow copy.
// Define FWD_HAZARD_FWD_EN to enable forwarding; otherwise every dependence stalls until its producer reaches WB.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall,
   output logic              bubble
);

   shadow_t           ex_reg;
   shadow_t           mem_reg;
   shadow_t           ex_next;
   logic [REG_AW-1:0] src_addr [2];
   logic [1:0]        src_use;
   logic [1:0]        match_ex;
   logic [1:0]        match_mem;
   logic              hazard;
   logic              advance;
   logic [1:0]        fwd_a_next;
   logic [1:0]        fwd_b_next;
   logic              unused_mem_ld;

   assign src_addr[0] = id_rs;
   assign src_addr[1] = id_rt;
   assign src_use     = {id_use_rt, id_use_rs};

   // Index 0 is rs (operand A), index 1 is rt (operand B).
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         dep_cmp #(.REG_AW(REG_AW)) u_cmp_ex (
            .src_use  (src_use[gi]),
            .addr     (src_addr[gi]),
            .stage_v  (ex_reg.v),
            .stage_rd (ex_reg.rd),
            .match    (match_ex[gi])
         );
         dep_cmp #(.REG_AW(REG_AW)) u_cmp_mem (
            .src_use  (src_use[gi]),
            .addr     (src_addr[gi]),
            .stage_v  (mem_reg.v),
            .stage_rd (mem_reg.rd),
            .match    (match_mem[gi])
         );
      end
   endgenerate

`ifdef FWD_HAZARD_FWD_EN
   // Only a load in EX cannot be forwarded in time.
   assign hazard = id_valid && ex_reg.ld && (|match_ex);
`else
   assign hazard = id_valid && ((|match_ex) || (|match_mem));
`endif

   assign stall   = hazard && !flush;
   assign advance = id_valid && !stall && !flush;

   always_comb begin
      ex_next = SHADOW_EMPTY;
      if (advance) begin
         ex_next.v  = id_regwrite;
         ex_next.ld = id_memread && id_regwrite;
         ex_next.rd = shadow_rd_t'(id_rd);
      end
   end

   always_comb begin
      fwd_a_next = FWD_RF;
      fwd_b_next = FWD_RF;
`ifdef FWD_HAZARD_FWD_EN
      if (advance) begin
         fwd_a_next = fwd_sel(match_ex[0], match_mem[0]);
         fwd_b_next = fwd_sel(match_ex[1], match_mem[1]);
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_reg  <= SHADOW_EMPTY;
         mem_reg <= SHADOW_EMPTY;
         fwd_a   <= FWD_RF;
         fwd_b   <= FWD_RF;
         bubble  <= 1'b1;
      end else begin
         mem_reg <= ex_reg;
         ex_reg  <= ex_next;
         fwd_a   <= fwd_a_next;
         fwd_b   <= fwd_b_next;
         bubble  <= !advance;
      end
   end

   // The load flag only matters while the producer is in EX.
   assign unused_mem_ld = mem_reg.ld;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit; expectations follow whether FWD_HAZARD_FWD_EN is defined.
module tb_fwd_hazard_unit;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_use_rs;
   logic       id_use_rt;
   logic [4:0] id_rd;
   logic       id_regwrite;
   logic       id_memread;
   logic       flush;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic       stall;
   logic       bubble;

   int total;
   int bad;

   fwd_hazard_unit #(.REG_AW(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .id_memread  (id_memread),
      .flush       (flush),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b),
      .stall       (stall),
      .bubble      (bubble)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Present one ID instruction and let the combinational stall settle.
   task automatic issue(input string name, input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic fl);
      id_valid    = v;
      id_rs       = rs;
      id_use_rs   = urs;
      id_rt       = rt;
      id_use_rt   = urt;
      id_rd       = rd;
      id_regwrite = rw;
      id_memread  = mr;
      flush       = fl;
      #1;
      $display("t=%0t %s v=%0b rs=%0d/%0b rt=%0d/%0b rd=%0d rw=%0b ld=%0b flush=%0b -> stall=%0b",
               $time, name, v, rs, urs, rt, urt, rd, rw, mr, fl, stall);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
      id_rd = 0; id_regwrite = 0; id_memread = 0; flush = 0;
      #12;
      chk("reset_fwd_a", 8'(fwd_a), 8'h0);
      chk("reset_fwd_b", 8'(fwd_b), 8'h0);
      chk("reset_bubble", 8'(bubble), 8'h1);
      chk("reset_stall", 8'(stall), 8'h0);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef FWD_HAZARD_FWD_EN
      issue("add r3,r1,r2", 1, 1, 1, 2, 1, 3, 1, 0, 0);
      chk("alu_prod_stall", 8'(stall), 8'h0);
      tick();
      chk("alu_prod_bubble", 8'(bubble), 8'h0);
      chk("alu_prod_fwd_a", 8'(fwd_a), 8'h0);
      issue("sub r5,r3,r4", 1, 3, 1, 4, 1, 5, 1, 0, 0);
      chk("exmem_stall", 8'(stall), 8'h0);
      tick();
      chk("exmem_fwd_a", 8'(fwd_a), 8'h1);
      chk("exmem_fwd_b", 8'(fwd_b), 8'h0);
      chk("exmem_bubble", 8'(bubble), 8'h0);

      issue("add r10,r1,r1", 1, 1, 1, 1, 1, 10, 1, 0, 0);
      tick();
      chk("prod_r10_fwd_a", 8'(fwd_a), 8'h0);
      issue("add r11,r1,r2", 1, 1, 1, 2, 1, 11, 1, 0, 0);
      tick();
      issue("add r12,r1,r10", 1, 1, 1, 10, 1, 12, 1, 0, 0);
      chk("memwb_stall", 8'(stall), 8'h0);
      tick();
      chk("memwb_fwd_b", 8'(fwd_b), 8'h2);
      chk("memwb_fwd_a", 8'(fwd_a), 8'h0);

      issue("lw r2,0(r1)", 1, 1, 1, 0, 0, 2, 1, 1, 0);
      tick();
      issue("add r6,r2,r2", 1, 2, 1, 2, 1, 6, 1, 0, 0);
      chk("loaduse_stall", 8'(stall), 8'h1);
      tick();
      chk("loaduse_bubble", 8'(bubble), 8'h1);
      chk("loaduse_bubble_fwd_a", 8'(fwd_a), 8'h0);
      chk("loaduse_restall", 8'(stall), 8'h0);
      tick();
      chk("loaduse_fwd_a", 8'(fwd_a), 8'h2);
      chk("loaduse_fwd_b", 8'(fwd_b), 8'h2);
      chk("loaduse_after_bubble", 8'(bubble), 8'h0);

      issue("add r7,r1,r1", 1, 1, 1, 1, 1, 7, 1, 0, 0);
      tick();
      issue("add r7,r1,r1 again", 1, 1, 1, 1, 1, 7, 1, 0, 0);
      tick();
      issue("add r13,r7,r1", 1, 7, 1, 1, 1, 13, 1, 0, 0);
      tick();
      chk("b2b_fwd_a", 8'(fwd_a), 8'h1);

      issue("add r0,r1,r1", 1, 1, 1, 1, 1, 0, 1, 0, 0);
      tick();
      issue("add r14,r0,r0", 1, 0, 1, 0, 1, 14, 1, 0, 0);
      chk("r0_stall", 8'(stall), 8'h0);
      tick();
      chk("r0_fwd_a", 8'(fwd_a), 8'h0);
      chk("r0_fwd_b", 8'(fwd_b), 8'h0);

      issue("add r3,r1,r1", 1, 1, 1, 1, 1, 3, 1, 0, 0);
      tick();
      issue("op r15 rs=r3 unused", 1, 3, 0, 4, 1, 15, 1, 0, 0);
      tick();
      chk("nouse_fwd_a", 8'(fwd_a), 8'h0);

      issue("lw r2,0(r1)", 1, 1, 1, 0, 0, 2, 1, 1, 0);
      tick();
      issue("add r6,r2,r2", 1, 2, 1, 2, 1, 6, 1, 0, 0);
      chk("flush_pre_stall", 8'(stall), 8'h1);
      issue("add r6,r2,r2 flushed", 1, 2, 1, 2, 1, 6, 1, 0, 1);
      chk("flush_stall", 8'(stall), 8'h0);
      tick();
      chk("flush_bubble", 8'(bubble), 8'h1);
      chk("flush_fwd_a", 8'(fwd_a), 8'h0);
      chk("flush_fwd_b", 8'(fwd_b), 8'h0);

      issue("lw r2,0(r1)", 1, 1, 1, 0, 0, 2, 1, 1, 0);
      tick();
      issue("add r6,r2,r2", 1, 2, 1, 2, 1, 6, 1, 0, 0);
      chk("rst_pre_stall", 8'(stall), 8'h1);
`else
      issue("add r3,r1,r2", 1, 1, 1, 2, 1, 3, 1, 0, 0);
      chk("alu_prod_stall", 8'(stall), 8'h0);
      tick();
      chk("alu_prod_bubble", 8'(bubble), 8'h0);
      chk("alu_prod_fwd_a", 8'(fwd_a), 8'h0);
      issue("sub r5,r3,r4", 1, 3, 1, 4, 1, 5, 1, 0, 0);
      chk("nofwd_stall1", 8'(stall), 8'h1);
      tick();
      chk("nofwd_bubble1", 8'(bubble), 8'h1);
      chk("nofwd_stall2", 8'(stall), 8'h1);
      chk("nofwd_fwd_a1", 8'(fwd_a), 8'h0);
      tick();
      chk("nofwd_bubble2", 8'(bubble), 8'h1);
      chk("nofwd_stall3", 8'(stall), 8'h0);
      tick();
      chk("nofwd_issue_bubble", 8'(bubble), 8'h0);
      chk("nofwd_fwd_a", 8'(fwd_a), 8'h0);
      chk("nofwd_fwd_b", 8'(fwd_b), 8'h0);

      issue("add r0,r6,r7", 1, 6, 1, 7, 1, 0, 1, 0, 0);
      chk("r0_prod_stall", 8'(stall), 8'h0);
      tick();
      issue("add r8,r0,r0", 1, 0, 1, 0, 1, 8, 1, 0, 0);
      chk("r0_stall", 8'(stall), 8'h0);
      tick();
      chk("r0_bubble", 8'(bubble), 8'h0);

      issue("add r3,r6,r7", 1, 6, 1, 7, 1, 3, 1, 0, 0);
      tick();
      issue("op r9 rs=r3 unused", 1, 3, 0, 4, 1, 9, 1, 0, 0);
      chk("nouse_stall", 8'(stall), 8'h0);
      issue("op r9 rs=r3 used", 1, 3, 1, 4, 1, 9, 1, 0, 0);
      chk("use_stall", 8'(stall), 8'h1);
      issue("op r9 rs=r3 flushed", 1, 3, 1, 4, 1, 9, 1, 0, 1);
      chk("flush_stall", 8'(stall), 8'h0);
      tick();
      chk("flush_bubble", 8'(bubble), 8'h1);
      chk("flush_fwd_a", 8'(fwd_a), 8'h0);

      issue("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("idle_bubble", 8'(bubble), 8'h1);
      issue("add r9,r6,r7", 1, 6, 1, 7, 1, 9, 1, 0, 0);
      tick();
      issue("add r10,r9,r1", 1, 9, 1, 1, 1, 10, 1, 0, 0);
      chk("rst_pre_stall", 8'(stall), 8'h1);
`endif

      // Reset while the stall is active: stall must drop at once and state must clear.
      rst_n = 1'b0;
      #1;
      chk("rst_stall", 8'(stall), 8'h0);
      chk("rst_bubble", 8'(bubble), 8'h1);
      chk("rst_fwd_a", 8'(fwd_a), 8'h0);
      $display("t=%0t reset asserted during stall -> stall=%0b bubble=%0b", $time, stall, bubble);
      tick();
      rst_n = 1'b1;
      #1;
      chk("post_rst_stall", 8'(stall), 8'h0);
      tick();
      chk("post_rst_bubble", 8'(bubble), 8'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
